// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester side and the uart_tx side of the frame arbiter.
//   master : drives enable, per-requester valid and flattened data.
//   slave  : the arbiter; drives ready pulses, grant, tx word/pulse, busy.
//
// Handshake: requester k holds i_req_valid[k] and its slice of i_req_data
// stable until it sees o_req_ready[k]=1. The word is taken at the clock
// edge that raises ready. In the ready-high cycle, the requester may drop
// valid or present a new word. o_tx_valid is a one-cycle pulse toward
// uart_tx, which has no back-pressure. Pacing comes from the hold-off.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 16
);
  logic                          i_tx_enable;
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            o_grant;
  logic [DATA_WIDTH-1:0]         o_tx_data;
  logic                          o_tx_valid;
  logic                          o_busy;

  modport master (
    output i_tx_enable, i_req_valid, i_req_data,
    input  o_req_ready, o_grant, o_tx_data, o_tx_valid, o_busy
  );

  modport slave (
    input  i_tx_enable, i_req_valid, i_req_data,
    output o_req_ready, o_grant, o_tx_data, o_tx_valid, o_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and frame pacer in front of a uart_tx serializer.
//   uart_tx has no busy flag, so after each word this block waits for a
//   fixed whole-frame interval (HOLD clocks) before it grants again.
// Ports:
//   i_clk_sys   : system clock
//   i_rst_n     : asynchronous active-low reset
//   bus         : uart_tx_arbiter_if.slave (requests in, ready/grant/tx out)
//   o_dbg_state : current FSM state (0 = IDLE, 1 = WAIT)
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 16,
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 9600,
  parameter int GUARD_BITS = 1
) (
  input  logic             i_clk_sys,
  input  logic             i_rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic             o_dbg_state
);
  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  // The interval covers start, data, stop, one bit of uart_tx launch latency, and guard bits.
  localparam int HOLD  = (DATA_WIDTH + 3 + GUARD_BITS) * CYCLE;
  localparam int CNT_W = $clog2(HOLD + 1);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic                  found;
  logic [PTR_W-1:0]      win;
  logic [PTR_W-1:0]      cand;
  int                    sum;

  // Search from the pointer upward with wrap. The first pending requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    sum   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = PTR_W'(sum);
      if (!found && bus.i_req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ready_d = '0;
    valid_d = 1'b0;
    grant_d = grant_q;
    data_d  = data_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_tx_enable && found) begin
          data_d  = bus.i_req_data[win*DATA_WIDTH +: DATA_WIDTH];
          valid_d = 1'b1;
          ready_d = NUM_REQ'(1) << win;
          grant_d = NUM_REQ'(1) << win;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(HOLD - 1);
          ptr_d   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The frame always completes. Enable only gates the next grant.
        if (cnt_q == '0) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= '0;
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_req_ready = ready_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_tx_data   = data_q;
  assign bus.o_tx_valid  = valid_q;
  assign bus.o_busy      = busy_q;
  assign o_dbg_state     = (state_q == S_WAIT);
endmodule
